// File: rtl/md_pkg.sv
// Shared op encoding, FSM states and op-class helpers for the multiply/divide unit.
// The decoder imports this package too, so the encoding must stay stable.
package md_pkg;

  typedef enum logic [3:0] {
    MD_NOP   = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MADD  = 4'd5,
    MD_MSUB  = 4'd6,
    MD_MTHI  = 4'd7,
    MD_MTLO  = 4'd8
  } md_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } md_state_t;

  // Ops that run the iterative datapath and end with a HI/LO commit.
  function automatic logic is_arith(md_op_t op);
    case (op)
      MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MADD, MD_MSUB: return 1'b1;
      default:                                              return 1'b0;
    endcase
  endfunction

  function automatic logic is_signed(md_op_t op);
    case (op)
      MD_MULT, MD_DIV, MD_MADD, MD_MSUB: return 1'b1;
      default:                           return 1'b0;
    endcase
  endfunction

  function automatic logic is_mul(md_op_t op);
    case (op)
      MD_MULT, MD_MULTU, MD_MADD, MD_MSUB: return 1'b1;
      default:                             return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/iter_muldiv_if.sv
// Decoder/hazard-unit facing bundle of the multiply/divide unit.
interface iter_muldiv_if #(
  parameter int WIDTH = 32
);
  import md_pkg::*;

  logic             start;
  md_op_t           op;
  logic             cancel;
  logic [WIDTH-1:0] rs;
  logic [WIDTH-1:0] rt;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, cancel, rs, rt,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, cancel, rs, rt,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/iter_muldiv.sv
// Iterative radix-2 shift-add multiplier / restoring divider with HI/LO registers.
// One 2*WIDTH shift register and one WIDTH+1 adder/subtractor serve both op classes.
module iter_muldiv
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          reset,
  iter_muldiv_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  md_state_t          state_reg, state_next;
  logic [2*WIDTH-1:0] sr_reg, sr_next;
  logic [WIDTH-1:0]   opb_reg, opb_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  md_op_t             op_reg, op_next;
  logic               sa_reg, sa_next;
  logic               sb_reg, sb_next;
  logic [WIDTH-1:0]   hi_reg, hi_next;
  logic [WIDTH-1:0]   lo_reg, lo_next;
  logic               done_reg, done_next;

  logic [WIDTH-1:0]   abs_rs, abs_rt;
  logic [WIDTH:0]     add_a, add_b, add_res;
  logic [2*WIDTH-1:0] sr_step;
  logic [2*WIDTH-1:0] prod_s, acc, mul_res, div_res, fix_res;
  logic [WIDTH-1:0]   quo, rem;
  logic               mul_op;

  assign abs_rs = (is_signed(bus.op) && bus.rs[WIDTH-1]) ? -bus.rs : bus.rs;
  assign abs_rt = (is_signed(bus.op) && bus.rt[WIDTH-1]) ? -bus.rt : bus.rt;
  assign mul_op = is_mul(op_reg);

  // Multiply adds the multiplicand to the upper half; divide trial-subtracts the
  // divisor from the remainder extended with the next dividend bit.
  always_comb begin
    add_a   = mul_op ? {1'b0, sr_reg[2*WIDTH-1:WIDTH]} : sr_reg[2*WIDTH-1:WIDTH-1];
    add_b   = {1'b0, opb_reg};
    add_res = mul_op ? (add_a + add_b) : (add_a - add_b);
    sr_step = sr_reg;
    if (mul_op) begin
      if (sr_reg[0]) sr_step = {add_res, sr_reg[WIDTH-1:1]};
      else           sr_step = {1'b0, sr_reg[2*WIDTH-1:1]};
    end else begin
      if (!add_res[WIDTH]) sr_step = {add_res[WIDTH-1:0], sr_reg[WIDTH-2:0], 1'b1};
      else                 sr_step = {sr_reg[2*WIDTH-2:0], 1'b0};
    end
  end

  // A zero divisor always passes the trial subtract, so the quotient saturates to
  // all ones and the remainder collects |rs|; sign fix-up then yields the defined
  // divide-by-zero results without a special case. MIN/-1 likewise falls out.
  always_comb begin
    acc    = {hi_reg, lo_reg};
    prod_s = (sa_reg ^ sb_reg) ? -sr_reg : sr_reg;
    case (op_reg)
      MD_MADD: mul_res = acc + prod_s;
      MD_MSUB: mul_res = acc - prod_s;
      default: mul_res = prod_s;
    endcase
    quo     = sr_reg[WIDTH-1:0];
    rem     = sr_reg[2*WIDTH-1:WIDTH];
    div_res = {(sa_reg ? -rem : rem), ((sa_reg ^ sb_reg) ? -quo : quo)};
    fix_res = mul_op ? mul_res : div_res;
  end

  always_comb begin
    state_next = state_reg;
    sr_next    = sr_reg;
    opb_next   = opb_reg;
    cnt_next   = cnt_reg;
    op_next    = op_reg;
    sa_next    = sa_reg;
    sb_next    = sb_reg;
    hi_next    = hi_reg;
    lo_next    = lo_reg;
    done_next  = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (bus.start && !bus.cancel) begin
          if (is_arith(bus.op)) begin
            op_next    = bus.op;
            sa_next    = is_signed(bus.op) & bus.rs[WIDTH-1];
            sb_next    = is_signed(bus.op) & bus.rt[WIDTH-1];
            cnt_next   = CNT_W'(WIDTH);
            state_next = S_CALC;
            if (is_mul(bus.op)) begin
              sr_next  = {{WIDTH{1'b0}}, abs_rt};
              opb_next = abs_rs;
            end else begin
              sr_next  = {{WIDTH{1'b0}}, abs_rs};
              opb_next = abs_rt;
            end
          end else if (bus.op == MD_MTHI) begin
            hi_next = bus.rs;
          end else if (bus.op == MD_MTLO) begin
            lo_next = bus.rs;
          end
        end
      end
      S_CALC: begin
        if (bus.cancel) begin
          state_next = S_IDLE;
        end else begin
          sr_next  = sr_step;
          cnt_next = cnt_reg - CNT_W'(1);
          if (cnt_reg == CNT_W'(1)) state_next = S_FIX;
        end
      end
      S_FIX: begin
        state_next = S_IDLE;
        if (!bus.cancel) begin
          {hi_next, lo_next} = fix_res;
          done_next          = 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IDLE;
      sr_reg    <= '0;
      opb_reg   <= '0;
      cnt_reg   <= '0;
      op_reg    <= MD_NOP;
      sa_reg    <= 1'b0;
      sb_reg    <= 1'b0;
      hi_reg    <= '0;
      lo_reg    <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      sr_reg    <= sr_next;
      opb_reg   <= opb_next;
      cnt_reg   <= cnt_next;
      op_reg    <= op_next;
      sa_reg    <= sa_next;
      sb_reg    <= sb_next;
      hi_reg    <= hi_next;
      lo_reg    <= lo_next;
      done_reg  <= done_next;
    end
  end

  // Combinational on start so the issuing cycle already stalls dependents.
  assign bus.busy = (state_reg != S_IDLE) | (bus.start & is_arith(bus.op) & ~bus.cancel);
  assign bus.done = done_reg;
  assign bus.hi   = hi_reg;
  assign bus.lo   = lo_reg;

endmodule

// File: tb/tb_iter_muldiv.sv
// Directed bench for iter_muldiv at WIDTH=32 with hand-computed HI/LO results.
module tb_iter_muldiv;
  import md_pkg::*;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  int   proto_cnt;

  iter_muldiv_if #(.WIDTH(32)) bus ();

  iter_muldiv #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Protocol monitor: start presented while an op is in flight.
  initial proto_cnt = 0;
  always @(posedge clk) begin
    if (!reset && bus.start && (dut.state_reg != S_IDLE)) begin
      proto_cnt++;
      $display("protocol: start while busy at %0t (dropped)", $time);
    end
  end

  // Called #1 after an edge; returns with start sampled at E0 and time at E0+1.
  task automatic issue(input md_op_t o, input logic [31:0] a, input logic [31:0] b,
                       output logic busy_at_issue);
    bus.start = 1'b1;
    bus.op    = o;
    bus.rs    = a;
    bus.rt    = b;
    #1;
    busy_at_issue = bus.busy;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.op    = MD_NOP;
  endtask

  // lat counts edges after E0 until done is seen; -1 if the bound expires.
  task automatic wait_done(output int lat, output int bcnt);
    lat  = 0;
    bcnt = bus.busy ? 1 : 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (!bus.done && bus.busy) bcnt++;
    end while (!bus.done && lat < 100);
    if (!bus.done) lat = -1;
  endtask

  task automatic run_op(input string name, input md_op_t o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo);
    logic bi;
    int   lat, bc;
    issue(o, a, b, bi);
    wait_done(lat, bc);
    $display("%s rs=%h rt=%h -> hi=%h lo=%h lat=%0d", name, a, b, bus.hi, bus.lo, lat);
    n_checks++;
    if (bus.hi !== exp_hi) begin
      n_fail++;
      $display("FAIL %s_hi actual=%h expected=%h", name, bus.hi, exp_hi);
    end
    n_checks++;
    if (bus.lo !== exp_lo) begin
      n_fail++;
      $display("FAIL %s_lo actual=%h expected=%h", name, bus.lo, exp_lo);
    end
    n_checks++;
    if (lat !== 33) begin
      n_fail++;
      $display("FAIL %s_latency actual=%0d expected=33", name, lat);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    $display("reset: busy=%b done=%b hi=%h lo=%h", bus.busy, bus.done, bus.hi, bus.lo);
    n_checks++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_flags actual=%b expected=00", {bus.busy, bus.done});
    end
    n_checks++;
    if ({bus.hi, bus.lo} !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_hilo actual=%h expected=0", {bus.hi, bus.lo});
    end
  endtask

  task automatic test_multu_timing();
    logic bi;
    int   lat, bc;
    issue(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, bi);
    wait_done(lat, bc);
    $display("MULTU ffffffff*ffffffff -> hi=%h lo=%h lat=%0d busy_cycles=%0d", bus.hi, bus.lo, lat, bc);
    n_checks++;
    if (bi !== 1'b1) begin
      n_fail++;
      $display("FAIL multu_busy_issue actual=%b expected=1", bi);
    end
    n_checks++;
    if ({bus.hi, bus.lo} !== 64'hFFFFFFFE_00000001) begin
      n_fail++;
      $display("FAIL multu_result actual=%h expected=fffffffe00000001", {bus.hi, bus.lo});
    end
    n_checks++;
    if (lat !== 33) begin
      n_fail++;
      $display("FAIL multu_latency actual=%0d expected=33", lat);
    end
    n_checks++;
    if (bc !== 33) begin
      n_fail++;
      $display("FAIL multu_busy_cycles actual=%0d expected=33", bc);
    end
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL multu_busy_at_done actual=%b expected=0", bus.busy);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL multu_done_width actual=%b expected=0", bus.done);
    end
  endtask

  task automatic test_signed();
    run_op("MULT -3*7", MD_MULT, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
    run_op("DIV -7/2", MD_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("DIV 7/-2", MD_DIV, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
    run_op("DIVU 100/7", MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
  endtask

  task automatic test_div_corner();
    run_op("DIV min/-1", MD_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    run_op("DIVU 5/0", MD_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF);
    run_op("DIV -5/0", MD_DIV, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'h00000001);
    run_op("DIV 5/0", MD_DIV, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF);
  endtask

  task automatic test_mthi_mtlo_mac();
    logic bi;
    issue(MD_MTHI, 32'h0, 32'h0, bi);
    n_checks++;
    if ({bi, bus.busy, bus.done} !== 3'b000) begin
      n_fail++;
      $display("FAIL mthi_flags actual=%b expected=000", {bi, bus.busy, bus.done});
    end
    issue(MD_MTLO, 32'd5, 32'h0, bi);
    $display("MTHI 0, MTLO 5 -> hi=%h lo=%h", bus.hi, bus.lo);
    n_checks++;
    if ({bus.hi, bus.lo, bus.done} !== {64'h0000000000000005, 1'b0}) begin
      n_fail++;
      $display("FAIL mtlo_write actual=%h done=%b expected=0000000000000005 done=0",
               {bus.hi, bus.lo}, bus.done);
    end
    run_op("MADD 2*3", MD_MADD, 32'd2, 32'd3, 32'h00000000, 32'h0000000B);
    run_op("MSUB 4*4", MD_MSUB, 32'd4, 32'd4, 32'hFFFFFFFF, 32'hFFFFFFFB);
  endtask

  task automatic test_cancel();
    logic bi;
    int   seen;
    issue(MD_DIV, 32'd100, 32'd7, bi);
    repeat (9) @(posedge clk);
    #1;
    bus.cancel = 1'b1;
    @(posedge clk);
    #1;
    bus.cancel = 1'b0;
    $display("cancel DIV at CALC cycle 10 -> busy=%b", bus.busy);
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL cancel_busy actual=%b expected=0", bus.busy);
    end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) seen++;
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL cancel_done actual=%0d expected=0", seen);
    end
    n_checks++;
    if ({bus.hi, bus.lo} !== 64'hFFFFFFFF_FFFFFFFB) begin
      n_fail++;
      $display("FAIL cancel_hilo actual=%h expected=fffffffffffffffb", {bus.hi, bus.lo});
    end
    run_op("DIVU after cancel 100/7", MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
  endtask

  task automatic test_reset_mid_op();
    logic bi;
    int   seen;
    issue(MD_MULTU, 32'd3, 32'd5, bi);
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    $display("reset at CALC cycle 5 -> busy=%b hi=%h lo=%h", bus.busy, bus.hi, bus.lo);
    n_checks++;
    if ({bus.busy, bus.done, bus.hi, bus.lo} !== 66'h0) begin
      n_fail++;
      $display("FAIL midreset_state actual=%h expected=0", {bus.busy, bus.done, bus.hi, bus.lo});
    end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) seen++;
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL midreset_done actual=%0d expected=0", seen);
    end
  endtask

  task automatic test_start_cancel();
    bus.start  = 1'b1;
    bus.op     = MD_MULT;
    bus.rs     = 32'd2;
    bus.rt     = 32'd3;
    bus.cancel = 1'b1;
    #1;
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL startcancel_busy_comb actual=%b expected=0", bus.busy);
    end
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
    bus.cancel = 1'b0;
    bus.op     = MD_NOP;
    repeat (3) @(posedge clk);
    #1;
    $display("start+cancel MULT 2*3 -> busy=%b hi=%h lo=%h", bus.busy, bus.hi, bus.lo);
    n_checks++;
    if ({bus.busy, bus.done, bus.hi, bus.lo} !== 66'h0) begin
      n_fail++;
      $display("FAIL startcancel_ignored actual=%h expected=0", {bus.busy, bus.done, bus.hi, bus.lo});
    end
  endtask

  task automatic test_back_to_back();
    logic bi;
    int   lat, bc, p0;
    p0 = proto_cnt;
    issue(MD_MULTU, 32'd3, 32'd5, bi);
    repeat (3) @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.op    = MD_DIV;
    bus.rs    = 32'd1;
    bus.rt    = 32'd1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.op    = MD_NOP;
    wait_done(lat, bc);
    lat = (lat < 0) ? lat : lat + 4;
    $display("MULTU 3*5 with stray start -> hi=%h lo=%h lat=%0d flagged=%0d", bus.hi, bus.lo, lat, proto_cnt - p0);
    n_checks++;
    if ({bus.hi, bus.lo} !== 64'h0000000F) begin
      n_fail++;
      $display("FAIL strayst_result actual=%h expected=000000000000000f", {bus.hi, bus.lo});
    end
    n_checks++;
    if (lat !== 33) begin
      n_fail++;
      $display("FAIL strayst_latency actual=%0d expected=33", lat);
    end
    n_checks++;
    if (proto_cnt !== p0 + 1) begin
      n_fail++;
      $display("FAIL strayst_flagged actual=%0d expected=%0d", proto_cnt, p0 + 1);
    end
    issue(MD_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, bi);
    n_checks++;
    if (bi !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_busy_issue actual=%b expected=1", bi);
    end
    wait_done(lat, bc);
    $display("MULT -1*-1 back-to-back -> hi=%h lo=%h lat=%0d", bus.hi, bus.lo, lat);
    n_checks++;
    if ({bus.hi, bus.lo} !== 64'h1 || lat !== 33) begin
      n_fail++;
      $display("FAIL b2b_result actual=%h lat=%0d expected=0000000000000001 lat=33", {bus.hi, bus.lo}, lat);
    end
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.op     = MD_NOP;
    bus.cancel = 1'b0;
    bus.rs     = '0;
    bus.rt     = '0;
    test_reset();
    test_multu_timing();
    test_signed();
    test_div_corner();
    test_mthi_mtlo_mac();
    test_cancel();
    test_reset_mid_op();
    test_start_cancel();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
